array_mult_accumulator: RTL and testbench

- Downstream consumer of the unsigned 8-bit array multiplier: accepts a burst of 16-bit unsigned products over a valid/ready handshake.
- Sums the products into a wider accumulator.
- Presents the total on a valid/ready result port.
- Turns the combinational multiplier array into a dot-product / MAC datapath, with a sticky overflow flag.

---
 rtl/array_mult_accumulator.sv | 107 ++++++++++
 tb/tb_array_mult_accumulator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : array_mult_accumulator
// Brief    : Sums a handshaked burst of unsigned products into a wide
//            accumulator with a sticky overflow flag (MAC / dot-product tail).
// Revision : 1.0 - initial release
// ============================================================================
module array_mult_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] product,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [ACC_W:0]     w_sum;

    // One extra bit captures the carry-out of the ACC_W-bit add.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt = '0;
                    w_ovf_nxt = 1'b0;
                    if (len != '0) begin
                        w_cnt_nxt   = len;
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_ACCUM: begin
                if (prod_valid) begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (acc_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Handshake outputs come straight from the state register.
    assign busy       = (r_state == S_ACCUM) || (r_state == S_HOLD);
    assign prod_ready = (r_state == S_ACCUM);
    assign acc_valid  = (r_state == S_HOLD);
    assign acc_out    = r_acc;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_array_mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_mult_accumulator
// Brief    : Scoreboard bench driving a 24-bit and a 16-bit accumulator in
//            lockstep from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_mult_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [15:0] product;
    logic        acc_ready;

    logic        busy_a, prod_ready_a, acc_valid_a, overflow_a;
    logic [23:0] acc_out_a;
    logic        busy_b, prod_ready_b, acc_valid_b, overflow_b;
    logic [15:0] acc_out_b;

    typedef struct {
        logic [23:0] s24;
        logic        o24;
        logic [15:0] s16;
        logic        o16;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_err;
    int unsigned m_sum;
    int          m_rem;
    logic        r_prev_valid;

    array_mult_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_a),
        .prod_valid(prod_valid), .prod_ready(prod_ready_a), .product(product),
        .acc_valid(acc_valid_a), .acc_ready(acc_ready), .acc_out(acc_out_a),
        .overflow(overflow_a)
    );

    array_mult_accumulator #(.PROD_W(16), .ACC_W(16), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_b),
        .prod_valid(prod_valid), .prod_ready(prod_ready_b), .product(product),
        .acc_valid(acc_valid_b), .acc_ready(acc_ready), .acc_out(acc_out_b),
        .overflow(overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.s24 = m_sum[23:0];
        e.o24 = (m_sum >= 32'h0100_0000);
        e.s16 = m_sum[15:0];
        e.o16 = (m_sum >= 32'h0001_0000);
        sb.push_back(e);
    endtask

    // Called at a falling edge; the following rising edge accepts the start.
    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        m_sum = 0;
        m_rem = int'(l);
        if (l == 8'd0) push_expected();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Leaves prod_valid high so consecutive calls are back-to-back.
    task automatic send(input logic [15:0] p);
        int k;
        prod_valid = 1'b1;
        product    = p;
        k = 0;
        while (!prod_ready_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) chk("send_ready_timeout", 32'(prod_ready_a), 32'd1);
        m_sum += 32'(p);
        m_rem--;
        if (m_rem == 0) push_expected();
        @(negedge clk);
    endtask

    task automatic take_result();
        int k;
        k = 0;
        while (!acc_valid_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) chk("result_timeout", 32'(acc_valid_a), 32'd1);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    // Scoreboard: compare on the first cycle each result is presented.
    always @(negedge clk) begin
        if (acc_valid_a && !r_prev_valid) begin
            chk("valid_lockstep", 32'(acc_valid_b), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(acc_valid_a), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("acc_out_24", 32'(acc_out_a), 32'(e.s24));
                chk("overflow_24", 32'(overflow_a), 32'(e.o24));
                chk("acc_out_16", 32'(acc_out_b), 32'(e.s16));
                chk("overflow_16", 32'(overflow_b), 32'(e.o16));
            end
        end
        r_prev_valid <= acc_valid_a;
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_sum = 0;
        m_rem = 0;
        r_prev_valid = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        len = 8'd0;
        prod_valid = 1'b0;
        product = 16'd0;
        acc_ready = 1'b0;

        #2;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_prod_ready", 32'(prod_ready_a), 32'd0);
        chk("rst_acc_valid", 32'(acc_valid_a), 32'd0);
        chk("rst_acc_out", 32'(acc_out_a), 32'd0);
        chk("rst_overflow", 32'(overflow_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-burst discards the partial sum
        do_start(8'd4);
        send(16'h0010);
        send(16'h0020);
        prod_valid = 1'b0;
        chk("mid_busy", 32'(busy_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_prod_ready", 32'(prod_ready_a), 32'd0);
        chk("mid_rst_acc_out", 32'(acc_out_a), 32'd0);
        chk("mid_rst_overflow", 32'(overflow_a), 32'd0);
        #1 rst_n = 1'b1;
        m_rem = 0;
        @(negedge clk);
        do_start(8'd1);
        send(16'h0005);
        prod_valid = 1'b0;
        take_result();

        // Basic burst, back-to-back products
        do_start(8'd3);
        send(16'h0006);
        send(16'h00FF);
        send(16'h1000);
        prod_valid = 1'b0;
        chk("basic_valid_latency", 32'(acc_valid_a), 32'd1);
        chk("basic_prod_ready_low", 32'(prod_ready_a), 32'd0);
        take_result();
        chk("basic_idle_after", 32'(busy_a), 32'd0);

        // Bubbles, backpressure and ignored starts
        do_start(8'd2);
        send(16'hFFFF);
        prod_valid = 1'b0;
        repeat (3) @(negedge clk);
        send(16'h0001);
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(acc_valid_a), 32'd1);
            chk("stall_acc_out", 32'(acc_out_a), 32'h0001_0000);
            start = 1'b1;
            len   = 8'd7;
            @(negedge clk);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_ready = 1'b0;
        chk("handshake_start_ignored", 32'(busy_a), 32'd0);
        @(negedge clk);
        chk("stay_idle", 32'(busy_a), 32'd0);

        // Empty burst
        do_start(8'd0);
        chk("empty_hold_valid", 32'(acc_valid_a), 32'd1);
        chk("empty_prod_ready", 32'(prod_ready_a), 32'd0);
        take_result();

        // Overflow on the 16-bit instance, then cleared by the next start
        do_start(8'd2);
        send(16'hFFFF);
        send(16'h0002);
        prod_valid = 1'b0;
        take_result();
        do_start(8'd1);
        chk("ovf_cleared_on_start", 32'(overflow_b), 32'd0);
        send(16'h0003);
        prod_valid = 1'b0;
        take_result();

        // Max burst
        do_start(8'd255);
        for (int i = 0; i < 255; i++) send(16'hFFFF);
        chk("max_prod_ready_drop", 32'(prod_ready_a), 32'd0);
        chk("max_valid", 32'(acc_valid_a), 32'd1);
        @(negedge clk);
        prod_valid = 1'b0;
        chk("max_sum_held", 32'(acc_out_a), 32'h00FE_FF01);
        take_result();

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
